// File: rtl/ela_frame_check.sv
`default_nettype none
// ============================================================================
// Module      : ela_frame_check
// Description : Compares a deinterlaced result frame against a golden frame
//               and accumulates error statistics. One pixel per cycle is read
//               from both memories at a shared address. Each pixel is
//               compared one cycle after its address is issued.
//
// Ports
//   clk             : clock, all logic on the rising edge
//   rst             : synchronous active-high reset
//   start           : one-cycle scan request (ignored while scanning)
//   mem_addr        : pixel address shared by the result and golden memories
//   mem_ren         : read enable for both memories
//   res_rd          : result-memory data, valid one cycle after its address
//   gold_rd         : golden-memory data, valid one cycle after its address
//   busy            : scan in progress
//   done            : scan complete, held until the next start or rst
//   sad             : sum of absolute differences
//   err_cnt         : number of pixels whose difference exceeds TOL
//   max_diff        : largest absolute difference seen
//   first_err_addr  : address of the first pixel counted as an error
//   first_err_valid : first_err_addr holds a captured address
//   pass            : done and no errors
//
// Revision    : 1.0 - initial release
// ============================================================================
module ela_frame_check #(
    parameter int TOL  = 0,
    parameter int NPIX = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [12:0] mem_addr,
    output logic        mem_ren,
    input  logic [7:0]  res_rd,
    input  logic [7:0]  gold_rd,
    output logic        busy,
    output logic        done,
    output logic [20:0] sad,
    output logic [13:0] err_cnt,
    output logic [7:0]  max_diff,
    output logic [12:0] first_err_addr,
    output logic        first_err_valid,
    output logic        pass
);

    localparam logic [1:0]  c_idle  = 2'd0;
    localparam logic [1:0]  c_read  = 2'd1;
    localparam logic [1:0]  c_drain = 2'd2;
    localparam logic [1:0]  c_done  = 2'd3;

    localparam logic [7:0]  c_tol   = TOL[7:0];
    localparam logic [12:0] c_last  = 13'(NPIX - 1);

    logic [1:0]  r_state;
    // Valid flag and address travelling alongside the one-cycle memory latency
    logic        r_pix_vld;
    logic [12:0] r_pix_addr;

    logic [7:0]  w_diff;
    logic        w_is_err;
    logic [20:0] w_sad_nxt;
    logic [13:0] w_err_nxt;
    logic [7:0]  w_max_nxt;

    always_comb begin
        w_diff    = (res_rd >= gold_rd) ? (res_rd - gold_rd) : (gold_rd - res_rd);
        w_is_err  = 1'b0;
        w_sad_nxt = sad;
        w_err_nxt = err_cnt;
        w_max_nxt = max_diff;
        if (r_pix_vld) begin
            w_is_err  = (w_diff > c_tol);
            w_sad_nxt = sad + {13'd0, w_diff};
            w_err_nxt = err_cnt + {13'd0, w_is_err};
            if (w_diff > max_diff) begin
                w_max_nxt = w_diff;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= c_idle;
            r_pix_vld       <= 1'b0;
            r_pix_addr      <= 13'd0;
            mem_addr        <= 13'd0;
            mem_ren         <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            sad             <= 21'd0;
            err_cnt         <= 14'd0;
            max_diff        <= 8'd0;
            first_err_addr  <= 13'd0;
            first_err_valid <= 1'b0;
        end else begin
            r_pix_vld  <= mem_ren;
            r_pix_addr <= mem_addr;

            sad      <= w_sad_nxt;
            err_cnt  <= w_err_nxt;
            max_diff <= w_max_nxt;
            if (w_is_err && !first_err_valid) begin
                first_err_addr  <= r_pix_addr;
                first_err_valid <= 1'b1;
            end

            case (r_state)
                c_idle, c_done: begin
                    if (start) begin
                        // Later assignments override the (idle) accumulate path
                        r_state         <= c_read;
                        mem_addr        <= 13'd0;
                        mem_ren         <= 1'b1;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        sad             <= 21'd0;
                        err_cnt         <= 14'd0;
                        max_diff        <= 8'd0;
                        first_err_addr  <= 13'd0;
                        first_err_valid <= 1'b0;
                    end
                end
                c_read: begin
                    if (mem_addr == c_last) begin
                        r_state <= c_drain;
                        mem_ren <= 1'b0;
                    end else begin
                        mem_addr <= mem_addr + 13'd1;
                    end
                end
                c_drain: begin
                    // Last pixel is accumulated on this edge, so pass uses the
                    // post-accumulation error count.
                    r_state <= c_done;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    pass    <= (w_err_nxt == 14'd0);
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ela_frame_check.md
ELA_FRAME_CHECK -- requirements
Module: ela_frame_check

Interface
REQ-001 Parameter TOL, default 0, absolute pixel difference at or below which a pixel is not an error.
REQ-002 Parameter NPIX, default 8192, number of pixels scanned (128x64 frame).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to scan; driven by the deinterlacer's done.
REQ-006 mem_addr  output  13  pixel address, shared by the result and golden memories.
REQ-007 mem_ren  output  1  read enable for both memories.
REQ-008 res_rd  input  8  result-memory read data, valid one cycle after its address.
REQ-009 gold_rd  input  8  golden-memory read data, valid one cycle after its address.
REQ-010 busy  output  1  high while scanning.
REQ-011 done  output  1  high from scan completion until the next start or rst.
REQ-012 sad  output  21  sum of absolute differences.
REQ-013 err_cnt  output  14  count of pixels with diff > TOL.
REQ-014 max_diff  output  8  largest absolute difference seen.
REQ-015 first_err_addr  output  13  address of the first error pixel.
REQ-016 first_err_valid  output  1  first_err_addr holds a captured address.
REQ-017 pass  output  1  done and err_cnt equals 0.

Function
REQ-018 The FSM SHALL have four states: IDLE, READ, DRAIN, DONE.
REQ-019 IDLE to READ when start=1: mem_addr<=0, mem_ren<=1, busy<=1, done<=0, all accumulators and first_err_valid cleared.
REQ-020 READ SHALL increment mem_addr by 1 per cycle; after the cycle presenting NPIX-1 it SHALL go to DRAIN with mem_ren<=0 and mem_addr held at NPIX-1.
REQ-021 Pipeline: the pixel addressed in cycle n SHALL be compared and accumulated at the end of cycle n+1, using a registered valid flag.
REQ-022 diff = |res_rd - gold_rd| in 8 bits; sad += diff, zero-extended to 21 bits, with no saturation.
REQ-023 diff > TOL SHALL increment err_cnt; on the first such pixel, first_err_addr <= pipelined address and first_err_valid <= 1.
REQ-024 max_diff <= diff when diff > max_diff.
REQ-025 DRAIN SHALL last one cycle, accumulating pixel NPIX-1, then go to DONE with busy<=0 and done<=1 on the same edge.
REQ-026 Latency: done SHALL be first high NPIX+1 cycles after the edge that sampled start (8193 at default).
REQ-027 start during READ or DRAIN SHALL be ignored.
REQ-028 start in DONE SHALL restart exactly as from IDLE; done SHALL fall on the next edge.
REQ-029 In DONE, results SHALL hold stable; mem_ren=0.
REQ-030 pass SHALL be registered and equal done and err_cnt==0.

Reset
REQ-031 rst SHALL force IDLE: mem_addr=0, mem_ren=0, busy=0, done=0, pass=0, sad=0, err_cnt=0, max_diff=0, first_err_addr=0, first_err_valid=0, pipeline valid=0.
REQ-032 rst mid-scan SHALL abort immediately with no partial result retained; rst has priority over start.

Verification
REQ-033 Identical memories, TOL=0, start pulse -> done after 8193 cycles, sad=0, err_cnt=0, max_diff=0, first_err_valid=0, pass=1.
REQ-034 Single mismatch at 0x1234 (res 0x80, gold 0x7D) -> sad=3, err_cnt=1, max_diff=3, first_err_addr=0x1234, pass=0.
REQ-035 All res=0xFF, gold=0x00 -> sad=2088960, err_cnt=8192, max_diff=255, first_err_addr=0.
REQ-036 TOL=2, diff 2 at 10 addresses and diff 3 at 0x0100 -> sad=23, err_cnt=1, first_err_addr=0x0100, max_diff=3.
REQ-037 rst at cycle 4000 of a scan -> all outputs at reset values the next cycle; a following start yields correct full results.
REQ-038 start pulses at cycles 10 and 8192 of a scan -> ignored, done still at 8193; start in DONE -> done falls next cycle and a new scan runs.
